// File: rtl/soin_bpredictor_bimodal_p.sv
// soin_bpredictor_bimodal_p
// Bimodal direction predictor with an optional return-address stack.
// The table holds 2^IDX_W saturating counters, indexed by PC[IDX_W+1:2].
// After reset an init FSM writes INIT_CTR into every entry.
// Lookup and update happen in the same clock.
// - The PC is registered and the counter is read synchronously, so the
//   prediction lines up with the instruction that fetch returns one
//   cycle later.
// - Execute sends back the meta word {ras_ptr, ctr, idx}. The predictor
//   writes sat(ctr +/- 1) to idx itself; execute never supplies the
//   counter value directly.
// Optional feature: define SOIN_BP_RAS_EN to build the return-address
// stack. Without it, ret is predicted not-taken, the meta ras_ptr field
// is always 0 and RAS recovery is ignored.
module soin_bpredictor_bimodal_p #(
    parameter int IDX_W       = 12,
    parameter int CTR_W       = 2,
    parameter int INIT_CTR    = 1,
    parameter int RAS_DEPTH_L = 4,
    localparam int META_W     = RAS_DEPTH_L + CTR_W + IDX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bp_stall,
    input  logic [31:0]       fetch_bpredictor_PC,
    input  logic [31:0]       fetch_bpredictor_inst,
    input  logic              fetch_redirect,
    input  logic [31:0]       fetch_redirect_PC,
    output logic [31:0]       bpredictor_fetch_p_target,
    output logic              bpredictor_fetch_p_dir,
    output logic [META_W-1:0] bpredictor_fetch_meta,
    output logic              bpredictor_init_busy,
    input  logic              execute_bpredictor_update,
    input  logic              execute_bpredictor_dir,
    input  logic [META_W-1:0] execute_bpredictor_meta,
    input  logic              execute_bpredictor_recover_ras
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [IDX_W-1:0] IDX_LAST = '1;
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_ZERO = '0;
    localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT_CTR);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t           state_q;
    logic [IDX_W-1:0] init_cnt_q;
    logic [31:0]      pc_q;
    logic [IDX_W-1:0] idx_q;
    logic [CTR_W-1:0] ctr_q;
    logic [CTR_W-1:0] ctr_mem [0:DEPTH-1];

    // Decode of the instruction at the registered PC
    logic [5:0]  opcode, opx;
    logic        is_cond, is_call, is_jmpi, is_rtype, is_callr, is_ret;
    logic [31:0] pc4, imm16s, br_target, jmp_target;

    assign opcode   = fetch_bpredictor_inst[5:0];
    assign opx      = fetch_bpredictor_inst[16:11];
    assign is_cond  = (opcode == 6'h06) || (opcode == 6'h0e) || (opcode == 6'h16) ||
                      (opcode == 6'h1e) || (opcode == 6'h26) || (opcode == 6'h2e) ||
                      (opcode == 6'h36);
    assign is_call  = (opcode == 6'h00);
    assign is_jmpi  = (opcode == 6'h01);
    assign is_rtype = (opcode == 6'h3a);
    assign is_callr = is_rtype && (opx == 6'h1d);
    assign is_ret   = is_rtype && (opx == 6'h05);

    assign pc4        = pc_q + 32'd4;
    assign imm16s     = {{16{fetch_bpredictor_inst[21]}}, fetch_bpredictor_inst[21:6]};
    assign br_target  = {pc4[31:2] + imm16s[31:2], 2'b00};
    assign jmp_target = {pc_q[31:28], fetch_bpredictor_inst[31:6], 2'b00};

    // Update path: the new counter is derived from the counter carried in meta
    logic [IDX_W-1:0] upd_idx;
    logic [CTR_W-1:0] upd_ctr, upd_ctr_new;
    logic             upd_we;

    assign upd_idx = execute_bpredictor_meta[IDX_W-1:0];
    assign upd_ctr = execute_bpredictor_meta[IDX_W +: CTR_W];
    assign upd_we  = execute_bpredictor_update && (state_q == ST_RUN);

    // Saturating increment/decrement of the returned counter
    always_comb begin
        upd_ctr_new = upd_ctr;
        if (execute_bpredictor_dir) begin
            if (upd_ctr != CTR_MAX) upd_ctr_new = upd_ctr + CTR_ONE;
        end else begin
            if (upd_ctr != CTR_ZERO) upd_ctr_new = upd_ctr - CTR_ONE;
        end
    end

    // Single table write port, shared by init clearing and execute updates
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [CTR_W-1:0] wr_data;

    assign wr_en   = (state_q == ST_INIT) || upd_we;
    assign wr_idx  = (state_q == ST_INIT) ? init_cnt_q : upd_idx;
    assign wr_data = (state_q == ST_INIT) ? CTR_INIT : upd_ctr_new;
    assign rd_idx  = bp_stall ? idx_q : fetch_bpredictor_PC[IDX_W+1:2];

    // Counter table storage
    always_ff @(posedge clk) begin
        if (wr_en) ctr_mem[wr_idx] <= wr_data;
    end

    // Init FSM: clears one entry per cycle, then stays in RUN until reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q              <= ST_INIT;
            init_cnt_q           <= '0;
            bpredictor_init_busy <= 1'b1;
        end else if (state_q == ST_INIT) begin
            init_cnt_q <= init_cnt_q + IDX_ONE;
            if (init_cnt_q == IDX_LAST) begin
                state_q              <= ST_RUN;
                bpredictor_init_busy <= 1'b0;
            end
        end
    end

    // Lookup registers; a same-cycle update to the read index is forwarded
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= '0;
            idx_q <= '0;
            ctr_q <= '0;
        end else begin
            if (!bp_stall) begin
                pc_q  <= fetch_bpredictor_PC;
                idx_q <= fetch_bpredictor_PC[IDX_W+1:2];
            end
            ctr_q <= (upd_we && (upd_idx == rd_idx)) ? upd_ctr_new : ctr_mem[rd_idx];
        end
    end

    logic [RAS_DEPTH_L-1:0] ras_ptr_q;

`ifdef SOIN_BP_RAS_EN
    localparam int RAS_N = 1 << RAS_DEPTH_L;
    localparam logic [RAS_DEPTH_L-1:0] PTR_ONE = RAS_DEPTH_L'(1);

    logic [31:0] ras_mem [0:RAS_N-1];
    logic        ras_adv;
    logic [31:0] ras_top;

    assign ras_adv = !bp_stall && !fetch_redirect && (state_q == ST_RUN);
    assign ras_top = ras_mem[ras_ptr_q];

    // RAS pointer: recovery wins over push/pop, and the pointer wraps freely
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ras_ptr_q <= '0;
        end else if (execute_bpredictor_recover_ras) begin
            ras_ptr_q <= execute_bpredictor_meta[META_W-1 -: RAS_DEPTH_L];
        end else if (ras_adv && (is_call || is_callr)) begin
            ras_ptr_q <= ras_ptr_q + PTR_ONE;
        end else if (ras_adv && is_ret) begin
            ras_ptr_q <= ras_ptr_q - PTR_ONE;
        end
    end

    // RAS storage: a push writes the return address one slot above the top
    always_ff @(posedge clk) begin
        if (!execute_bpredictor_recover_ras && ras_adv && (is_call || is_callr))
            ras_mem[ras_ptr_q + PTR_ONE] <= pc4;
    end
`else
    logic unused_ras;
    assign ras_ptr_q  = '0;
    assign unused_ras = &{1'b0, execute_bpredictor_recover_ras, is_ret, is_callr,
                          execute_bpredictor_meta[META_W-1 -: RAS_DEPTH_L]};
`endif

    // Direction/target selection in priority order
    always_comb begin
        bpredictor_fetch_p_dir    = 1'b0;
        bpredictor_fetch_p_target = pc4;
        if (fetch_redirect) begin
            bpredictor_fetch_p_target = fetch_redirect_PC;
        end else if (state_q == ST_INIT) begin
            bpredictor_fetch_p_dir = 1'b0;
        end else if (is_cond) begin
            bpredictor_fetch_p_dir = ctr_q[CTR_W-1];
            if (ctr_q[CTR_W-1]) bpredictor_fetch_p_target = br_target;
        end else if (is_call || is_jmpi) begin
            bpredictor_fetch_p_dir    = 1'b1;
            bpredictor_fetch_p_target = jmp_target;
`ifdef SOIN_BP_RAS_EN
        end else if (is_ret) begin
            bpredictor_fetch_p_dir    = 1'b1;
            bpredictor_fetch_p_target = ras_top;
`endif
        end
    end

    assign bpredictor_fetch_meta = {ras_ptr_q, ctr_q, idx_q};

endmodule

// File: tb/tb_soin_bpredictor_bimodal_p.sv
// Directed bench for soin_bpredictor_bimodal_p (default parameters).
module tb_soin_bpredictor_bimodal_p;

    localparam int META_W = 18;

    localparam logic [31:0] I_NOP   = 32'h0000_0004;  // addi, not a control op
    localparam logic [31:0] I_BNE   = 32'h0000_041e;  // bne, imm16 = +0x10
    localparam logic [31:0] I_BNEN  = 32'h003f_fc1e;  // bne, imm16 = -0x10
    localparam logic [31:0] I_BR    = 32'h0000_0406;  // br, imm16 = +0x10
    localparam logic [31:0] I_CALL  = 32'h0000_4000;  // call, imm26 = 0x100
    localparam logic [31:0] I_JMPI  = 32'h0000_4001;  // jmpi, imm26 = 0x100
    localparam logic [31:0] I_RET   = 32'h0000_283a;
    localparam logic [31:0] I_CALLR = 32'h0000_e83a;

    logic              clk = 1'b0;
    logic              reset;
    logic              bp_stall;
    logic [31:0]       fetch_pc, fetch_inst, redirect_pc;
    logic              fetch_redirect;
    logic [31:0]       p_target;
    logic              p_dir;
    logic [META_W-1:0] p_meta;
    logic              init_busy;
    logic              ex_update, ex_dir, ex_recover;
    logic [META_W-1:0] ex_meta;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    soin_bpredictor_bimodal_p dut (
        .clk                            (clk),
        .reset                          (reset),
        .bp_stall                       (bp_stall),
        .fetch_bpredictor_PC            (fetch_pc),
        .fetch_bpredictor_inst          (fetch_inst),
        .fetch_redirect                 (fetch_redirect),
        .fetch_redirect_PC              (redirect_pc),
        .bpredictor_fetch_p_target      (p_target),
        .bpredictor_fetch_p_dir         (p_dir),
        .bpredictor_fetch_meta          (p_meta),
        .bpredictor_init_busy           (init_busy),
        .execute_bpredictor_update      (ex_update),
        .execute_bpredictor_dir         (ex_dir),
        .execute_bpredictor_meta        (ex_meta),
        .execute_bpredictor_recover_ras (ex_recover)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a fetch PC, then the instruction that arrives after the edge
    task automatic lookup(input logic [31:0] pc, input logic [31:0] inst);
        @(negedge clk);
        fetch_pc = pc;
        @(posedge clk);
        #1;
        fetch_inst = inst;
        #1;
    endtask

    task automatic upd(input logic dir, input logic [1:0] ctr, input logic [11:0] idx);
        @(negedge clk);
        ex_update = 1'b1;
        ex_dir    = dir;
        ex_meta   = {4'd0, ctr, idx};
        @(posedge clk);
        #1;
        ex_update = 1'b0;
    endtask

    // Count cycles with init_busy high after reset release, bounded
    task automatic wait_init(output int cycles);
        cycles = 0;
        while (cycles < 10000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (!init_busy) break;
        end
    endtask

    initial begin
        reset = 1'b0; bp_stall = 1'b0; fetch_pc = 32'h0; fetch_inst = I_NOP;
        fetch_redirect = 1'b0; redirect_pc = 32'h0;
        ex_update = 1'b0; ex_dir = 1'b0; ex_recover = 1'b0; ex_meta = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, init_busy}, 32'd1);
        chk("rst_dir", {31'd0, p_dir}, 32'd0);
        chk("rst_target", p_target, 32'h4);
        chk("rst_meta", {14'd0, p_meta}, 32'd0);
        fetch_redirect = 1'b1; redirect_pc = 32'h800; #1;
        chk("rst_redirect", p_target, 32'h800);
        fetch_redirect = 1'b0;

        // Init takes exactly 4096 cycles
        @(negedge clk);
        reset = 1'b1;
        wait_init(n);
        chk("init_cycles", n, 32'd4096);

        // Every entry reads INIT_CTR = 1
        lookup(32'h100, I_BNE);
        chk("init_dir", {31'd0, p_dir}, 32'd0);
        chk("init_target", p_target, 32'h104);
        chk("init_meta", {14'd0, p_meta}, {14'd0, 4'd0, 2'd1, 12'h040});
        lookup(32'h3ffc, I_BNE);
        chk("init_last_entry", {30'd0, p_meta[13:12]}, 32'd1);
        lookup(32'h0, I_BNE);
        chk("init_first_entry", {30'd0, p_meta[13:12]}, 32'd1);

        // Count up to saturation
        fetch_pc = 32'h100;
        upd(1'b1, 2'd1, 12'h040);
        upd(1'b1, 2'd2, 12'h040);
        upd(1'b1, 2'd3, 12'h040);
        lookup(32'h100, I_BNE);
        chk("sat_hi_ctr", {30'd0, p_meta[13:12]}, 32'd3);
        chk("taken_dir", {31'd0, p_dir}, 32'd1);
        chk("taken_target", p_target, 32'h114);
        lookup(32'h100, I_BNEN);
        chk("taken_neg_target", p_target, 32'hf4);

        // Count down to saturation
        upd(1'b0, 2'd3, 12'h040);
        upd(1'b0, 2'd2, 12'h040);
        upd(1'b0, 2'd1, 12'h040);
        upd(1'b0, 2'd0, 12'h040);
        lookup(32'h100, I_BNE);
        chk("sat_lo_ctr", {30'd0, p_meta[13:12]}, 32'd0);
        chk("nt_dir", {31'd0, p_dir}, 32'd0);
        chk("nt_target", p_target, 32'h104);
        lookup(32'h100, I_BR);
        chk("br_uses_ctr_dir", {31'd0, p_dir}, 32'd0);

        // Write-first bypass: update and lookup of idx 0x40 in one cycle
        @(negedge clk);
        fetch_pc = 32'h100; ex_update = 1'b1; ex_dir = 1'b1; ex_meta = {4'd0, 2'd1, 12'h040};
        @(posedge clk);
        #1;
        ex_update = 1'b0; fetch_inst = I_BNE; #1;
        chk("bypass_ctr", {30'd0, p_meta[13:12]}, 32'd2);
        chk("bypass_dir", {31'd0, p_dir}, 32'd1);

        // Stall holds PC and index
        @(negedge clk);
        bp_stall = 1'b1; fetch_pc = 32'h500;
        @(posedge clk);
        #1;
        chk("stall_meta", {14'd0, p_meta}, {14'd0, 4'd0, 2'd2, 12'h040});
        chk("stall_target", p_target, 32'h114);
        @(negedge clk);
        bp_stall = 1'b0;

        // Direct jumps
        lookup(32'h3000_0000, I_JMPI);
        chk("jmpi_dir", {31'd0, p_dir}, 32'd1);
        chk("jmpi_target", p_target, 32'h3000_0400);
        lookup(32'h3000_0004, I_NOP);

`ifdef SOIN_BP_RAS_EN
        lookup(32'h200, I_CALL);
        chk("call_target", p_target, 32'h400);
        lookup(32'h400, I_RET);
        chk("ret_dir", {31'd0, p_dir}, 32'd1);
        chk("ret_target", p_target, 32'h204);
        lookup(32'h404, I_NOP);
        lookup(32'h600, I_CALLR);
        chk("callr_dir", {31'd0, p_dir}, 32'd0);
        chk("callr_target", p_target, 32'h604);
        lookup(32'h700, I_RET);
        chk("callr_ret_target", p_target, 32'h604);
        lookup(32'h704, I_NOP);

        // 17 nested calls overflow a 16-deep stack
        for (int k = 0; k < 17; k++) lookup(32'h1000 + k * 32'h10, I_CALL);
        for (int r = 0; r < 17; r++) begin
            lookup(32'h2000 + r * 32'h4, I_RET);
            if (r == 0 || r == 16) chk("nest_ret", p_target, 32'h1104);
            else chk("nest_ret", p_target, 32'h1004 + (16 - r) * 32'h10);
        end
        lookup(32'h2100, I_NOP);
        chk("nest_ptr", {28'd0, p_meta[17:14]}, 32'd0);

        // Recover beats push
        lookup(32'h300, I_CALL);
        @(negedge clk);
        fetch_pc = 32'h304; ex_recover = 1'b1; ex_meta = {4'd3, 2'd0, 12'd0};
        @(posedge clk);
        #1;
        ex_recover = 1'b0; fetch_inst = I_NOP; #1;
        chk("recover_ptr", {28'd0, p_meta[17:14]}, 32'd3);

        // Redirect on a ret: redirect target, no pop
        lookup(32'h900, I_RET);
        fetch_redirect = 1'b1; redirect_pc = 32'h800; #1;
        chk("redir_target", p_target, 32'h800);
        chk("redir_dir", {31'd0, p_dir}, 32'd0);
        lookup(32'h904, I_NOP);
        fetch_redirect = 1'b0; #1;
        chk("redir_ptr", {28'd0, p_meta[17:14]}, 32'd3);
`else
        lookup(32'h200, I_CALL);
        chk("call_target", p_target, 32'h400);
        lookup(32'h400, I_RET);
        chk("noras_ret_dir", {31'd0, p_dir}, 32'd0);
        chk("noras_ret_target", p_target, 32'h404);
        chk("noras_ptr", {28'd0, p_meta[17:14]}, 32'd0);
        lookup(32'h600, I_CALLR);
        chk("callr_dir", {31'd0, p_dir}, 32'd0);
        chk("callr_target", p_target, 32'h604);
        @(negedge clk);
        fetch_pc = 32'h604; fetch_inst = I_NOP; ex_recover = 1'b1; ex_meta = {4'd3, 2'd0, 12'd0};
        @(posedge clk);
        #1;
        ex_recover = 1'b0; #1;
        chk("noras_recover_ignored", {28'd0, p_meta[17:14]}, 32'd0);
`endif

        // Reset during init restarts from entry 0 and runs a full pass
        @(negedge clk);
        fetch_inst = I_NOP; reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("mid_init_busy", {31'd0, init_busy}, 32'd1);
        lookup(32'h100, I_BNE);
        chk("init_dir_forced", {31'd0, p_dir}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        wait_init(n);
        chk("reinit_cycles", n, 32'd4096);
        lookup(32'h100, I_BNE);
        chk("reinit_ctr", {30'd0, p_meta[13:12]}, 32'd1);
        chk("reinit_dir", {31'd0, p_dir}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
